// File: rtl/reg_transfer_ctrl_if.sv
// Request/operand/result bundle between a transfer requester and reg_transfer_ctrl.
// The requester drives the operands and REG_OUT; the controller drives the register bus and status.
interface reg_transfer_ctrl_if #(
  parameter int unsigned SEL_W  = 2,
  parameter int unsigned DATA_W = 8
) ();
  localparam int unsigned NUM_REGS = 1 << SEL_W;

  logic                         REQ;
  logic [SEL_W-1:0]             SRC_SEL;
  logic [SEL_W-1:0]             DST_SEL;
  logic                         IMM_EN;
  logic [DATA_W-1:0]            IMM_DATA;
  logic [NUM_REGS*DATA_W-1:0]   REG_OUT;
  logic [DATA_W-1:0]            BUS_OUT;
  logic [NUM_REGS-1:0]          LOAD_OUT;
  logic                         BUSY;
  logic                         DONE;
  logic                         ERR;
  logic [7:0]                   XFER_CNT;

  modport master (
    output REQ, SRC_SEL, DST_SEL, IMM_EN, IMM_DATA, REG_OUT,
    input  BUS_OUT, LOAD_OUT, BUSY, DONE, ERR, XFER_CNT
  );

  modport slave (
    input  REQ, SRC_SEL, DST_SEL, IMM_EN, IMM_DATA, REG_OUT,
    output BUS_OUT, LOAD_OUT, BUSY, DONE, ERR, XFER_CNT
  );
endinterface

// File: rtl/reg_transfer_ctrl.sv
// Register-bank transfer sequencer: moves one byte (register or immediate) into a
// destination register via a fixed READ/WRITE/DONE sequence, counting successful moves.
module reg_transfer_ctrl #(
  parameter int unsigned SEL_W  = 2,
  parameter int unsigned DATA_W = 8
) (
  input  logic                  CLK,
  input  logic                  CLEAR,
  reg_transfer_ctrl_if.slave    bus
);
  localparam int unsigned NUM_REGS = 1 << SEL_W;
  localparam int unsigned CNT_W    = 8;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_e;

  state_e                state_q,    state_d;
  logic [SEL_W-1:0]      src_q,      src_d;
  logic [SEL_W-1:0]      dst_q,      dst_d;
  logic                  imm_en_q,   imm_en_d;
  logic [DATA_W-1:0]     imm_data_q, imm_data_d;
  logic [DATA_W-1:0]     hold_q,     hold_d;
  logic                  rej_q,      rej_d;
  logic [DATA_W-1:0]     bus_q,      bus_d;
  logic [NUM_REGS-1:0]   load_q,     load_d;
  logic                  busy_q,     busy_d;
  logic                  done_q,     done_d;
  logic                  err_q,      err_d;
  logic [CNT_W-1:0]      cnt_q,      cnt_d;

  // Next-state and next-output logic; outputs are registered one cycle behind the state.
  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    imm_en_d   = imm_en_q;
    imm_data_d = imm_data_q;
    hold_d     = hold_q;
    rej_d      = rej_q;
    bus_d      = bus_q;
    load_d     = '0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    cnt_d      = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.REQ) begin
          src_d      = bus.SRC_SEL;
          dst_d      = bus.DST_SEL;
          imm_en_d   = bus.IMM_EN;
          imm_data_d = bus.IMM_DATA;
          rej_d      = 1'b0;
          state_d    = S_READ;
        end
      end
      S_READ: begin
        hold_d  = imm_en_q ? imm_data_q
                           : bus.REG_OUT[32'(src_q) * DATA_W +: DATA_W];
        rej_d   = !imm_en_q && (src_q == dst_q);
        state_d = S_WRITE;
      end
      S_WRITE: begin
        // A rejected transfer still occupies this slot so DONE timing is uniform.
        if (!rej_q) begin
          bus_d  = hold_q;
          load_d = NUM_REGS'(1) << dst_q;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        done_d = 1'b1;
        err_d  = rej_q;
        if (!rej_q && (cnt_q != {CNT_W{1'b1}})) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (CLEAR) begin
      state_q    <= S_IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      imm_en_q   <= 1'b0;
      imm_data_q <= '0;
      hold_q     <= '0;
      rej_q      <= 1'b0;
      bus_q      <= '0;
      load_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      imm_en_q   <= imm_en_d;
      imm_data_q <= imm_data_d;
      hold_q     <= hold_d;
      rej_q      <= rej_d;
      bus_q      <= bus_d;
      load_q     <= load_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.BUS_OUT  = bus_q;
  assign bus.LOAD_OUT = load_q;
  assign bus.BUSY     = busy_q;
  assign bus.DONE     = done_q;
  assign bus.ERR      = err_q;
  assign bus.XFER_CNT = cnt_q;
endmodule

// File: tb/tb_reg_transfer_ctrl.sv
// Directed bench for reg_transfer_ctrl: reset, register/immediate moves, rejection,
// busy-time request filtering, counter saturation and abort by CLEAR.
module tb_reg_transfer_ctrl;
  logic clk = 1'b0;
  logic clear;
  int   total = 0;
  int   bad   = 0;

  reg_transfer_ctrl_if #(.SEL_W(2), .DATA_W(8)) bus_if ();

  reg_transfer_ctrl #(.SEL_W(2), .DATA_W(8)) dut (
    .CLK   (clk),
    .CLEAR (clear),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input logic [1:0] src, input logic [1:0] dst,
                        input logic imm, input logic [7:0] dat);
    bus_if.SRC_SEL  = src;
    bus_if.DST_SEL  = dst;
    bus_if.IMM_EN   = imm;
    bus_if.IMM_DATA = dat;
  endtask

  // One complete immediate transfer into register 1 (4 edges).
  task automatic xfer_imm(input logic [7:0] dat);
    set_op(2'd0, 2'd1, 1'b1, dat);
    bus_if.REQ = 1'b1;
    tick();
    bus_if.REQ = 1'b0;
    tick();
    tick();
    tick();
  endtask

  // Operand stream presented before each edge of the held-REQ phase.
  logic [1:0] t_src [9] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd2, 2'd1, 2'd0, 2'd3, 2'd3};
  logic [1:0] t_dst [9] = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd1, 2'd2, 2'd3, 2'd1, 2'd0};
  logic       t_imm [9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [7:0] t_dat [9] = '{8'h00, 8'hAA, 8'hBB, 8'hCC, 8'h5E, 8'h12, 8'h34, 8'h56, 8'h00};
  logic [3:0] e_load [12] = '{4'h0, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0};
  logic [7:0] e_bus  [12] = '{8'h3C, 8'h3C, 8'h22, 8'h22, 8'h22, 8'h22,
                              8'h5E, 8'h5E, 8'h5E, 8'h5E, 8'h44, 8'h44};
  logic       e_busy [12] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic       e_done [12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    // Reset with random operands and REQ asserted
    clear          = 1'b1;
    bus_if.REQ     = 1'b1;
    set_op(2'($urandom), 2'($urandom), 1'($urandom), 8'($urandom));
    bus_if.REG_OUT = 32'($urandom);
    tick();
    tick();
    chk("rst_bus",  32'(bus_if.BUS_OUT),  32'h0);
    chk("rst_load", 32'(bus_if.LOAD_OUT), 32'h0);
    chk("rst_busy", 32'(bus_if.BUSY),     32'h0);
    chk("rst_done", 32'(bus_if.DONE),     32'h0);
    chk("rst_err",  32'(bus_if.ERR),      32'h0);
    chk("rst_cnt",  32'(bus_if.XFER_CNT), 32'h0);
    clear      = 1'b0;
    bus_if.REQ = 1'b0;
    tick();
    chk("rst_req_dropped", 32'(bus_if.BUSY), 32'h0);

    // Register move r1 -> r2
    bus_if.REG_OUT = {8'h00, 8'h11, 8'hA5, 8'h22};
    set_op(2'd1, 2'd2, 1'b0, 8'hFF);
    bus_if.REQ = 1'b1;
    tick();
    bus_if.REQ = 1'b0;
    chk("mv_busy_e0", 32'(bus_if.BUSY),     32'h1);
    chk("mv_load_e0", 32'(bus_if.LOAD_OUT), 32'h0);
    tick();
    chk("mv_load_e1", 32'(bus_if.LOAD_OUT), 32'h0);
    tick();
    chk("mv_load_e2", 32'(bus_if.LOAD_OUT), 32'h4);
    chk("mv_bus_e2",  32'(bus_if.BUS_OUT),  32'hA5);
    chk("mv_done_e2", 32'(bus_if.DONE),     32'h0);
    tick();
    chk("mv_done_e3", 32'(bus_if.DONE),     32'h1);
    chk("mv_err_e3",  32'(bus_if.ERR),      32'h0);
    chk("mv_load_e3", 32'(bus_if.LOAD_OUT), 32'h0);
    chk("mv_cnt_e3",  32'(bus_if.XFER_CNT), 32'h1);
    chk("mv_busy_e3", 32'(bus_if.BUSY),     32'h0);
    chk("mv_bus_hold", 32'(bus_if.BUS_OUT), 32'hA5);
    tick();
    chk("mv_done_e4", 32'(bus_if.DONE),     32'h0);

    // Immediate load into r0 with SRC==DST
    set_op(2'd0, 2'd0, 1'b1, 8'h3C);
    bus_if.REQ = 1'b1;
    tick();
    bus_if.REQ = 1'b0;
    tick();
    tick();
    chk("imm_load", 32'(bus_if.LOAD_OUT), 32'h1);
    chk("imm_bus",  32'(bus_if.BUS_OUT),  32'h3C);
    tick();
    chk("imm_done", 32'(bus_if.DONE),     32'h1);
    chk("imm_err",  32'(bus_if.ERR),      32'h0);
    chk("imm_cnt",  32'(bus_if.XFER_CNT), 32'h2);
    tick();

    // Rejected register move r3 -> r3
    bus_if.REG_OUT = {8'h77, 8'h11, 8'hA5, 8'h22};
    set_op(2'd3, 2'd3, 1'b0, 8'h99);
    bus_if.REQ = 1'b1;
    tick();
    bus_if.REQ = 1'b0;
    tick();
    tick();
    chk("rej_load_e2", 32'(bus_if.LOAD_OUT), 32'h0);
    chk("rej_bus_e2",  32'(bus_if.BUS_OUT),  32'h3C);
    chk("rej_done_e2", 32'(bus_if.DONE),     32'h0);
    tick();
    chk("rej_done_e3", 32'(bus_if.DONE),     32'h1);
    chk("rej_err_e3",  32'(bus_if.ERR),      32'h1);
    chk("rej_load_e3", 32'(bus_if.LOAD_OUT), 32'h0);
    chk("rej_cnt_e3",  32'(bus_if.XFER_CNT), 32'h2);

    // REQ held high with operands changing every cycle
    bus_if.REG_OUT = {8'h44, 8'h33, 8'h22, 8'h11};
    for (int e = 0; e < 12; e++) begin
      if (e < 9) begin
        set_op(t_src[e], t_dst[e], t_imm[e], t_dat[e]);
        bus_if.REQ = 1'b1;
      end else begin
        bus_if.REQ = 1'b0;
      end
      tick();
      chk($sformatf("hold_load_e%0d", e), 32'(bus_if.LOAD_OUT), 32'(e_load[e]));
      chk($sformatf("hold_bus_e%0d",  e), 32'(bus_if.BUS_OUT),  32'(e_bus[e]));
      chk($sformatf("hold_busy_e%0d", e), 32'(bus_if.BUSY),     32'(e_busy[e]));
      chk($sformatf("hold_done_e%0d", e), 32'(bus_if.DONE),     32'(e_done[e]));
    end
    chk("hold_cnt", 32'(bus_if.XFER_CNT), 32'h5);
    chk("hold_err", 32'(bus_if.ERR),      32'h0);

    // Counter saturation: 5 + 250 = 255, then 10 more
    for (int n = 0; n < 250; n++) xfer_imm(8'(n));
    chk("sat_cnt_255", 32'(bus_if.XFER_CNT), 32'd255);
    for (int n = 0; n < 10; n++) xfer_imm(8'(n));
    chk("sat_cnt_hold", 32'(bus_if.XFER_CNT), 32'd255);

    // Abort by CLEAR while in READ
    set_op(2'd2, 2'd0, 1'b0, 8'h00);
    bus_if.REQ = 1'b1;
    tick();
    bus_if.REQ = 1'b0;
    chk("abt_busy_e0", 32'(bus_if.BUSY), 32'h1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("abt_cnt",  32'(bus_if.XFER_CNT), 32'h0);
    chk("abt_busy", 32'(bus_if.BUSY),     32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("abt_load_%0d", k), 32'(bus_if.LOAD_OUT), 32'h0);
      chk($sformatf("abt_done_%0d", k), 32'(bus_if.DONE),     32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
